// File: rtl/seg_wave_effect.sv
// Seven-segment reveal animation over NUM_DIGITS multiplexed digits,
// lockstep or cascaded per digit, with loop/one-shot sequencing.
module seg_wave_effect #(
    parameter int         NUM_DIGITS = 7,
    parameter int         CLK_HZ     = 50000000,
    parameter int         SCAN_DIV   = 25000,
    parameter logic [2:0] EFFECT_ID  = 3'b011
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [2:0]              enable,
    input  logic [1:0]              frequency,
    input  logic                    mode,
    input  logic                    one_shot,
    input  logic [7*NUM_DIGITS-1:0] char_seg,
    output logic [NUM_DIGITS-1:0]   trans,
    output logic [6:0]              led7seg,
    output logic [3:0]              frame,
    output logic                    done
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(NUM_DIGITS);
    localparam int TW = $clog2(CLK_HZ + 1);
    localparam int BW = $clog2(NUM_DIGITS + 10);
    localparam logic [TW-1:0] HZ = TW'(CLK_HZ);
    localparam logic [NUM_DIGITS-1:0] MSB_SEL = {1'b1, {(NUM_DIGITS-1){1'b0}}};

    logic [SW-1:0] r_scan;
    logic [DW-1:0] r_digit;
    logic [TW-1:0] r_timer;
    logic [BW-1:0] r_base;
    logic          r_was_active;
    logic          r_mode;
    logic          r_one_shot;
    logic          r_fired;
    logic          r_wrap;

    logic          w_active;
    logic          w_mode;
    logic          w_one_shot;
    logic [TW-1:0] w_period_m1;
    logic          w_expire;
    logic [BW-1:0] w_last;
    logic          w_at_end;
    logic          w_scan_wrap;
    logic [BW-1:0] w_lag;
    logic [BW-1:0] w_diff;
    logic [3:0]    w_fidx;
    logic [6:0]    w_char;
    logic [6:0]    w_pattern;

    assign w_active = (enable == EFFECT_ID);
    // Live inputs count only on the first active cycle; afterwards the latched copy.
    assign w_mode = r_was_active ? r_mode : mode;
    assign w_one_shot = r_was_active ? r_one_shot : one_shot;
    assign w_period_m1 = (HZ >> frequency) - TW'(1);
    assign w_expire = (r_timer >= w_period_m1);
    assign w_last = w_mode ? BW'(NUM_DIGITS + 9) : BW'(10);
    assign w_at_end = (r_base == w_last);
    assign w_scan_wrap = (r_scan == SW'(SCAN_DIV - 1));

    assign w_lag = w_mode ? BW'(r_digit) : '0;
    assign w_diff = (r_base >= w_lag) ? (r_base - w_lag) : '0;
    assign w_fidx = (w_diff > BW'(10)) ? 4'd10 : w_diff[3:0];

    always_comb begin
        w_char = 7'h7F;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (r_digit == DW'(d)) w_char = char_seg[7*d +: 7];
        end
    end

    always_comb begin
        w_pattern = 7'h7F;
        case (w_fidx)
            4'd1:  w_pattern = 7'b1101111;
            4'd2:  w_pattern = 7'b1011111;
            4'd3:  w_pattern = 7'b0111111;
            4'd4:  w_pattern = 7'b1110111;
            4'd5:  w_pattern = 7'b1101111;
            4'd6:  w_pattern = 7'b0111111;
            4'd7:  w_pattern = 7'b0111111;
            4'd8:  w_pattern = w_char;
            4'd9:  w_pattern = w_char;
            4'd10: w_pattern = w_char;
            default: w_pattern = 7'h7F;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan       <= '0;
            r_digit      <= '0;
            r_timer      <= '0;
            r_base       <= '0;
            r_was_active <= 1'b0;
            r_mode       <= 1'b0;
            r_one_shot   <= 1'b0;
            r_fired      <= 1'b0;
            r_wrap       <= 1'b0;
        end else if (!w_active) begin
            r_scan       <= '0;
            r_digit      <= '0;
            r_timer      <= '0;
            r_base       <= '0;
            r_was_active <= 1'b0;
            r_fired      <= 1'b0;
            r_wrap       <= 1'b0;
        end else begin
            r_was_active <= 1'b1;
            r_mode       <= w_mode;
            r_one_shot   <= w_one_shot;
            r_scan       <= w_scan_wrap ? '0 : r_scan + SW'(1);
            if (w_scan_wrap) begin
                r_digit <= (r_digit == DW'(NUM_DIGITS - 1)) ? '0 : r_digit + DW'(1);
            end
            r_wrap <= 1'b0;
            if (w_expire) begin
                r_timer <= '0;
                if (!w_at_end) begin
                    r_base <= r_base + BW'(1);
                end else if (!w_one_shot) begin
                    r_base <= '0;
                    r_wrap <= 1'b1;
                end else if (!r_fired) begin
                    r_fired <= 1'b1;
                    r_wrap  <= 1'b1;
                end
            end else begin
                r_timer <= r_timer + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trans   <= '1;
            led7seg <= 7'h7F;
            frame   <= 4'd0;
            done    <= 1'b0;
        end else if (!w_active) begin
            trans   <= '1;
            led7seg <= 7'h7F;
            frame   <= 4'd0;
            done    <= 1'b0;
        end else begin
            trans   <= ~(MSB_SEL >> r_digit);
            led7seg <= w_pattern;
            frame   <= r_base[3:0];
            done    <= r_wrap;
        end
    end
endmodule

// File: tb/tb_seg_wave_effect.sv
// Bench for seg_wave_effect: reference model compared every cycle,
// plus directed checks with hand-derived values.
module tb_seg_wave_effect;
    localparam int ND   = 3;
    localparam int CHZ  = 64;
    localparam int SDIV = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [2:0]      enable = 3'b000;
    logic [1:0]      frequency = 2'b11;
    logic            mode = 1'b0;
    logic            one_shot = 1'b0;
    logic [7*ND-1:0] char_seg = {7'h24, 7'h79, 7'h40};
    logic [ND-1:0]   trans;
    logic [6:0]      led7seg;
    logic [3:0]      frame;
    logic            done;

    int n_cmp = 0;
    int n_bad = 0;

    seg_wave_effect #(
        .NUM_DIGITS(ND),
        .CLK_HZ(CHZ),
        .SCAN_DIV(SDIV),
        .EFFECT_ID(3'b011)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .frequency(frequency),
        .mode(mode),
        .one_shot(one_shot),
        .char_seg(char_seg),
        .trans(trans),
        .led7seg(led7seg),
        .frame(frame),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] glyph(input int f, input logic [6:0] ch);
        logic [6:0] g;
        case (f)
            0: g = 7'h7F;
            1: g = 7'h6F;
            2: g = 7'h5F;
            3: g = 7'h3F;
            4: g = 7'h77;
            5: g = 7'h6F;
            6: g = 7'h3F;
            7: g = 7'h3F;
            default: g = ch;
        endcase
        return g;
    endfunction

    // Reference model: active-cycle count gives the digit directly,
    // base advances whenever the elapsed frame time reaches the period.
    int m_k = 0, m_base = 0, m_tick = 0;
    bit m_fired = 0, m_pend = 0, m_run = 0, m_lm = 0, m_los = 0;
    logic [ND-1:0] e_trans = '1;
    logic [6:0]    e_led = 7'h7F;
    logic [3:0]    e_frame = 4'd0;
    logic          e_done = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        int dig, f, len, per;
        logic [ND-1:0] one;
        if (!rst_n || enable != 3'b011) begin
            m_k = 0; m_base = 0; m_tick = 0;
            m_fired = 0; m_pend = 0; m_run = 0;
            e_trans = '1; e_led = 7'h7F; e_frame = 4'd0; e_done = 1'b0;
        end else begin
            if (!m_run) begin
                m_lm = mode; m_los = one_shot; m_run = 1;
            end
            len = m_lm ? 10 + ND : 11;
            dig = (m_k / SDIV) % ND;
            f = m_lm ? m_base - dig : m_base;
            if (f < 0) f = 0;
            if (f > 10) f = 10;
            one = 1;
            e_trans = ~(one << (ND - 1 - dig));
            e_led = glyph(f, char_seg[7*dig +: 7]);
            e_frame = 4'(m_base);
            e_done = m_pend;
            m_pend = 0;
            per = CHZ >> frequency;
            if (m_tick >= per - 1) begin
                m_tick = 0;
                if (m_base < len - 1) m_base++;
                else if (!m_los) begin m_base = 0; m_pend = 1; end
                else if (!m_fired) begin m_fired = 1; m_pend = 1; end
            end else begin
                m_tick++;
            end
            m_k++;
        end
    end

    always @(posedge clk) begin
        #1;
        check("m_trans", 32'(trans), 32'(e_trans));
        check("m_led", 32'(led7seg), 32'(e_led));
        check("m_frame", 32'(frame), 32'(e_frame));
        check("m_done", 32'(done), 32'(e_done));
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        wait_n(3);
        rst_n = 1'b1;
        wait_n(1);
        check("rst_trans", 32'(trans), 32'h7);
        check("rst_led", 32'(led7seg), 32'h7F);
        check("rst_frame", 32'(frame), 32'h0);
        check("rst_done", 32'(done), 32'h0);

        // lockstep loop, P = 8
        enable = 3'b011;
        wait_n(1);
        check("scan_d0", 32'(trans), 32'h3);
        check("blank_f0", 32'(led7seg), 32'h7F);
        wait_n(4);
        check("scan_d1", 32'(trans), 32'h5);
        wait_n(4);
        check("scan_d2", 32'(trans), 32'h6);
        check("lk_frame1", 32'(frame), 32'h1);
        wait_n(18);
        check("lk_f3_led", 32'(led7seg), 32'h3F);
        check("lk_frame3", 32'(frame), 32'h3);
        wait_n(38);
        check("lk_f8_d1", 32'(led7seg), 32'h79);
        check("lk_frame8", 32'(frame), 32'h8);
        wait_n(4);
        check("lk_f8_d2", 32'(led7seg), 32'h24);
        wait_n(20);
        check("lk_done", 32'(done), 32'h1);
        check("lk_wrap0", 32'(frame), 32'h0);
        wait_n(1);
        check("lk_done_1cyc", 32'(done), 32'h0);
        wait_n(11);

        // deactivate mid-sequence
        enable = 3'b010;
        wait_n(1);
        check("off_trans", 32'(trans), 32'h7);
        check("off_led", 32'(led7seg), 32'h7F);
        check("off_frame", 32'(frame), 32'h0);

        // re-enable at P = 64, then shorten period while timer is 20
        frequency = 2'b00;
        enable = 3'b011;
        wait_n(1);
        check("re_d0", 32'(trans), 32'h3);
        check("re_frame0", 32'(frame), 32'h0);
        wait_n(2);
        mode = 1'b1;
        wait_n(17);
        frequency = 2'b11;
        wait_n(1);
        check("fq_before", 32'(frame), 32'h0);
        wait_n(1);
        check("fq_step", 32'(frame), 32'h1);
        wait_n(7);
        check("fq_hold", 32'(frame), 32'h1);
        check("mode_ignored", 32'(led7seg), 32'h6F);
        wait_n(1);
        check("fq_next", 32'(frame), 32'h2);

        // cascade one-shot, L = 13
        enable = 3'b000;
        mode = 1'b1;
        one_shot = 1'b1;
        wait_n(1);
        enable = 3'b011;
        wait_n(1);
        wait_n(68);
        check("cs_d2_f6", 32'(led7seg), 32'h3F);
        wait_n(4);
        check("cs_d0_f9", 32'(led7seg), 32'h40);
        check("cs_base9", 32'(frame), 32'h9);
        wait_n(4);
        check("cs_d1_f8", 32'(led7seg), 32'h79);
        wait_n(4);
        check("cs_d2_f8", 32'(led7seg), 32'h24);
        wait_n(24);
        check("cs_done", 32'(done), 32'h1);
        check("cs_frame12", 32'(frame), 32'hC);
        wait_n(8);
        check("cs_no_redone", 32'(done), 32'h0);
        check("cs_hold12", 32'(frame), 32'hC);
        wait_n(20);

        // asynchronous reset during frame 9
        enable = 3'b000;
        mode = 1'b0;
        one_shot = 1'b0;
        wait_n(1);
        enable = 3'b011;
        wait_n(1);
        wait_n(75);
        check("pre_rst_frame", 32'(frame), 32'h9);
        #2 rst_n = 1'b0;
        #1;
        check("arst_trans", 32'(trans), 32'h7);
        check("arst_led", 32'(led7seg), 32'h7F);
        check("arst_frame", 32'(frame), 32'h0);
        check("arst_done", 32'(done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_n(1);
        check("post_rst_d0", 32'(trans), 32'h3);
        wait_n(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
